// File: rtl/eclair_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eclair_seq_pkg
// Description : Shared widths, state encoding and helpers for the ECL CPU
//               microcycle phase sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package eclair_seq_pkg;

    localparam int PHASE_W = 3;
    localparam int DWELL_W = 4;

    localparam logic [1:0] HALTED = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] STEP   = 2'd2;

    typedef enum logic [1:0] {
        ST_HALTED = HALTED,
        ST_RUN    = RUN,
        ST_STEP   = STEP
    } seq_state_t;

    // Wrap at the configured phase count is handled by the caller.
    function automatic logic [PHASE_W-1:0] phase_inc(input logic [PHASE_W-1:0] p);
        return p + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/eclair_phase_dwell.sv
`default_nettype none
// ============================================================================
// Module      : eclair_phase_dwell
// Description : Per-phase dwell counter with wait-state hold at terminal
//               count; reports terminal count and whether the next value is 0.
// Revision    : 1.0 - initial release
// ============================================================================
module eclair_phase_dwell
    import eclair_seq_pkg::*;
#(
    parameter int PHASE_CYCLES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic hold,
    output logic terminal,
    output logic zero_next
);

    localparam logic [DWELL_W-1:0] c_last_dwell = DWELL_W'(PHASE_CYCLES - 1);

    logic [DWELL_W-1:0] r_dwell;
    logic [DWELL_W-1:0] w_dwell_next;
    logic               w_terminal;

    assign w_terminal = (r_dwell == c_last_dwell);

    // Hold is only honoured on the terminal clock of a phase.
    always_comb begin
        w_dwell_next = r_dwell + 1'b1;
        if (clear) begin
            w_dwell_next = '0;
        end else if (w_terminal) begin
            w_dwell_next = hold ? r_dwell : '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dwell <= '0;
        end else begin
            r_dwell <= w_dwell_next;
        end
    end

    assign terminal  = w_terminal;
    assign zero_next = (w_dwell_next == '0);

endmodule
`default_nettype wire

// File: rtl/eclair_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : eclair_phase_sequencer
// Description : Microcycle phase sequencer driving an MC10H161-style 1-of-8
//               decoder (select + disable). Run / step / halt / wait control.
//               Optional macro PHASE_GUARD_EN masks select changes with disable.
// Revision    : 1.0 - initial release
// ============================================================================
module eclair_phase_sequencer
    import eclair_seq_pkg::*;
#(
    parameter int NUM_PHASES   = 8,
    parameter int PHASE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               run,
    input  logic               step,
    input  logic               halt_req,
    input  logic               wait_req,
    output logic [PHASE_W-1:0] phase,
    output logic               phase_disable,
    output logic               cycle_start,
    output logic               cycle_done,
    output logic               halted
);

    localparam logic [PHASE_W-1:0] c_last_phase = PHASE_W'(NUM_PHASES - 1);

    if ((NUM_PHASES < 2) || (NUM_PHASES > 8)) begin : g_num_phases_check
        $error("NUM_PHASES must be in 2..8");
    end
    if ((PHASE_CYCLES < 1) || (PHASE_CYCLES > 15)) begin : g_phase_cycles_check
        $error("PHASE_CYCLES must be in 1..15");
    end

`ifdef PHASE_GUARD_EN
    localparam bit c_guard_en = 1'b1;
    if (PHASE_CYCLES < 2) begin : g_guard_check
        $error("PHASE_GUARD_EN needs PHASE_CYCLES >= 2");
    end
`else
    localparam bit c_guard_en = 1'b0;
`endif

    seq_state_t         r_state;
    seq_state_t         w_state_next;
    logic [PHASE_W-1:0] r_phase;
    logic [PHASE_W-1:0] w_phase_next;
    logic               r_run_q;
    logic               r_halt_pend;
    logic               w_halt_pend_next;
    logic               r_phase_disable;
    logic               w_disable_next;
    logic               r_cycle_start;
    logic               w_start_next;
    logic               r_cycle_done;
    logic               w_done_next;
    logic               r_halted;
    logic               w_run_edge;
    logic               w_terminal;
    logic               w_zero_next;
    logic               w_advance;
    logic               w_clear;

    assign w_clear    = (r_state == ST_HALTED);
    assign w_run_edge = run & ~r_run_q;
    assign w_advance  = (r_state != ST_HALTED) && w_terminal && !wait_req;

    eclair_phase_dwell #(
        .PHASE_CYCLES (PHASE_CYCLES)
    ) u_dwell (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (w_clear),
        .hold      (wait_req),
        .terminal  (w_terminal),
        .zero_next (w_zero_next)
    );

    always_comb begin
        w_state_next = r_state;
        w_phase_next = r_phase;
        w_start_next = 1'b0;
        w_done_next  = 1'b0;

        case (r_state)
            ST_HALTED: begin
                w_phase_next = '0;
                if (w_run_edge) begin
                    w_state_next = ST_RUN;
                    w_start_next = 1'b1;
                end else if (step) begin
                    w_state_next = ST_STEP;
                    w_start_next = 1'b1;
                end
            end
            ST_RUN, ST_STEP: begin
                if (w_advance) begin
                    if (r_phase == c_last_phase) begin
                        w_phase_next = '0;
                        w_done_next  = 1'b1;
                        // A halt request arriving on the boundary clock still counts.
                        if ((r_state == ST_STEP) || r_halt_pend || halt_req || !run) begin
                            w_state_next = ST_HALTED;
                        end else begin
                            w_start_next = 1'b1;
                        end
                    end else begin
                        w_phase_next = phase_inc(r_phase);
                    end
                end
            end
            default: begin
                w_state_next = ST_HALTED;
                w_phase_next = '0;
            end
        endcase

        if (w_state_next == ST_HALTED) begin
            w_halt_pend_next = 1'b0;
        end else begin
            w_halt_pend_next = r_halt_pend | ((r_state != ST_HALTED) & halt_req);
        end

        w_disable_next = (w_state_next == ST_HALTED) | (c_guard_en & w_zero_next);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= ST_HALTED;
            r_phase         <= '0;
            r_run_q         <= 1'b1;
            r_halt_pend     <= 1'b0;
            r_phase_disable <= 1'b1;
            r_cycle_start   <= 1'b0;
            r_cycle_done    <= 1'b0;
            r_halted        <= 1'b1;
        end else begin
            r_state         <= w_state_next;
            r_phase         <= w_phase_next;
            r_run_q         <= run;
            r_halt_pend     <= w_halt_pend_next;
            r_phase_disable <= w_disable_next;
            r_cycle_start   <= w_start_next;
            r_cycle_done    <= w_done_next;
            r_halted        <= (w_state_next == ST_HALTED);
        end
    end

    assign phase         = r_phase;
    assign phase_disable = r_phase_disable;
    assign cycle_start   = r_cycle_start;
    assign cycle_done    = r_cycle_done;
    assign halted        = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_eclair_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_eclair_phase_sequencer
// Description : Directed, scoreboard-checked bench for eclair_phase_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eclair_phase_sequencer;

    localparam int NP = 8;
    localparam int PC = 2;
`ifdef PHASE_GUARD_EN
    localparam bit c_guard = 1'b1;
`else
    localparam bit c_guard = 1'b0;
`endif

    typedef struct {
        logic [2:0] phase;
        logic       dis;
        logic       start;
        logic       done;
        logic       halted;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       run;
    logic       step;
    logic       halt_req;
    logic       wait_req;
    logic [2:0] phase;
    logic       phase_disable;
    logic       cycle_start;
    logic       cycle_done;
    logic       halted;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    eclair_phase_sequencer #(
        .NUM_PHASES   (NP),
        .PHASE_CYCLES (PC)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .run           (run),
        .step          (step),
        .halt_req      (halt_req),
        .wait_req      (wait_req),
        .phase         (phase),
        .phase_disable (phase_disable),
        .cycle_start   (cycle_start),
        .cycle_done    (cycle_done),
        .halted        (halted)
    );

    // Expected outputs at position j (clock index) within an unstretched microcycle.
    function automatic exp_t exp_active(input int j);
        exp_t e;
        e.phase  = 3'(j / PC);
        e.dis    = c_guard ? ((j % PC) == 0) : 1'b0;
        e.start  = (j == 0);
        e.done   = 1'b0;
        e.halted = 1'b0;
        return e;
    endfunction

    function automatic exp_t exp_halted(input logic done);
        exp_t e;
        e.phase  = 3'd0;
        e.dis    = 1'b1;
        e.start  = 1'b0;
        e.done   = done;
        e.halted = 1'b1;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s observed=empty-scoreboard expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".phase"},   phase,                e.phase);
            chk({tag, ".disable"}, {2'b0, phase_disable}, {2'b0, e.dis});
            chk({tag, ".start"},   {2'b0, cycle_start},   {2'b0, e.start});
            chk({tag, ".done"},    {2'b0, cycle_done},    {2'b0, e.done});
            chk({tag, ".halted"},  {2'b0, halted},        {2'b0, e.halted});
        end
    endtask

    task automatic tick(input logic r, input logic s, input logic h, input logic w,
                        input exp_t e, input string tag);
        run      = r;
        step     = s;
        halt_req = h;
        wait_req = w;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        run = 1'b0; step = 1'b0; halt_req = 1'b0; wait_req = 1'b0;
        reset_n = 1'b1;

        // Reset, asserted away from any clock edge
        #2 reset_n = 1'b0;
        #1;
        sb.push_back(exp_halted(1'b0));
        compare("reset_async");
        repeat (2) tick(1'b0, 1'b0, 1'b0, 1'b0, exp_halted(1'b0), "reset_hold");
        reset_n = 1'b1;
        repeat (2) tick(1'b0, 1'b0, 1'b0, 1'b0, exp_halted(1'b0), "idle");

        // Single step; a second step pulse mid-cycle is ignored
        for (int k = 0; k < NP * PC; k++)
            tick(1'b0, (k == 0) || (k == 6), 1'b0, 1'b0, exp_active(k), $sformatf("step[%0d]", k));
        tick(1'b0, 1'b0, 1'b0, 1'b0, exp_halted(1'b1), "step_done");
        tick(1'b0, 1'b0, 1'b0, 1'b0, exp_halted(1'b0), "step_idle");

        // Run for three microcycles, run dropped at clock 48
        for (int k = 0; k < 3 * NP * PC; k++) begin
            e = exp_active(k % (NP * PC));
            if (k > 0 && (k % (NP * PC)) == 0) e.done = 1'b1;
            tick(1'b1, 1'b0, 1'b0, 1'b0, e, $sformatf("run[%0d]", k));
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0, exp_halted(1'b1), "run_done");
        tick(1'b0, 1'b0, 1'b0, 1'b0, exp_halted(1'b0), "run_idle");

        // Wait stretch of phase 3 by 5 clocks -> 21-clock microcycle
        for (int k = 0; k < NP * PC + 5; k++) begin
            if (k >= 8 && k <= 12)  e = exp_active(7);
            else if (k > 12)        e = exp_active(k - 5);
            else                    e = exp_active(k);
            tick(1'b1, 1'b0, 1'b0, (k >= 8 && k <= 12), e, $sformatf("wait[%0d]", k));
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0, exp_halted(1'b1), "wait_done");
        tick(1'b0, 1'b0, 1'b0, 1'b0, exp_halted(1'b0), "wait_idle");

        // Halt request in phase 2 with run held high
        for (int k = 0; k < NP * PC; k++)
            tick(1'b1, 1'b0, (k == 5), 1'b0, exp_active(k), $sformatf("halt[%0d]", k));
        tick(1'b1, 1'b0, 1'b0, 1'b0, exp_halted(1'b1), "halt_done");
        repeat (4) tick(1'b1, 1'b0, 1'b0, 1'b0, exp_halted(1'b0), "halt_hold");
        tick(1'b0, 1'b0, 1'b0, 1'b0, exp_halted(1'b0), "halt_runlow");

        // Restart, then reset in phase 5 with run held high
        for (int k = 0; k <= 10; k++)
            tick(1'b1, 1'b0, 1'b0, 1'b0, exp_active(k), $sformatf("restart[%0d]", k));
        #2 reset_n = 1'b0;
        #1;
        sb.push_back(exp_halted(1'b0));
        compare("midrun_reset");
        tick(1'b1, 1'b0, 1'b0, 1'b0, exp_halted(1'b0), "midrun_reset_held");
        reset_n = 1'b1;
        repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b0, exp_halted(1'b0), "post_reset_run_high");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/eclair_phase_sequencer.md
# eclair_phase_sequencer

Microcycle phase sequencer for the ECL CPU model. It steps a 3-bit phase number through a fixed number of phases and produces the select and active-high disable inputs of the 1-of-8 active-low phase decoder (MC10H161 model) directly downstream. It supports run, single-step, halt and wait-state stretching. It also masks decoder select transitions with a guard disable so that decoded phase strobes never glitch.

## Interface
- NUM_PHASES, 8, phases per microcycle (2..8)
- PHASE_CYCLES, 2, clocks each phase is held absent wait (1..15; ≥2 when guard compiled in)
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- run  in  1  level; a rising edge starts continuous sequencing; low ends it at the microcycle boundary
- step  in  1  one-clock pulse; runs exactly one microcycle from HALTED
- halt_req  in  1  one-clock pulse; latched; stops at the end of the current microcycle
- wait_req  in  1  level; stretches the current phase
- phase  out  3  decoder select
- phase_disable  out  1  decoder enable; 1 forces all decoder outputs high
- cycle_start  out  1  one-clock pulse in the first clock of phase 0
- cycle_done  out  1  one-clock pulse in the first clock after the last phase completes
- halted  out  1  high in HALTED

## Operation
- States: HALTED, RUN, STEP.
- Internal registers: dwell counter (4 bit), run_q (registered run), halt_pend latch.
- HALTED: phase=0, dwell=0, phase_disable=1. Exit conditions:
  - run rising edge (run & ~run_q) → RUN.
  - else step=1 → STEP.
  - run edge and step together → RUN.
  - Entering RUN or STEP sets phase=0, dwell=0 and pulses cycle_start.
- RUN/STEP dwell behaviour:
  - dwell increments each clock until PHASE_CYCLES-1.
  - At dwell==PHASE_CYCLES-1 with wait_req=0: dwell→0 and phase advances.
  - At dwell==PHASE_CYCLES-1 with wait_req=1: phase and dwell hold.
  - wait_req is ignored at any other dwell value.
- Advance from phase NUM_PHASES-1 (end of microcycle): phase→0 and cycle_done pulses. Then:
  - STEP → HALTED.
  - RUN with halt_pend=1 or run=0 → HALTED, clear halt_pend.
  - Otherwise stay in RUN and pulse cycle_start.
- halt_pend: set by halt_req in RUN or STEP; ignored in HALTED; cleared on entering HALTED.
- step in RUN/STEP: ignored.
- Arithmetic: phase wraps at NUM_PHASES, not at 8. Codes ≥NUM_PHASES are never driven.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- Reset (asynchronous, takes effect immediately, including mid-phase):
  - State outputs: state HALTED, phase 0, dwell 0, phase_disable 1, cycle_start 0, cycle_done 0, halted 1, halt_pend 0.
  - run_q=1, so a run level held high through reset does not start sequencing.
- Start latency: run edge or step sampled at edge N → phase 0 and cycle_start=1 from edge N. phase_disable follows the guard rule.
- Microcycle length: NUM_PHASES×PHASE_CYCLES clocks plus the total wait cycles.
- cycle_done coincides with the first HALTED clock or with the next cycle_start.

## Configuration
- PHASE_GUARD_EN defined:
  - phase_disable=1 in HALTED and in dwell==0 of every phase.
  - phase_disable=0 in all other RUN/STEP clocks, including wait-held clocks.
  - Elaboration error if PHASE_CYCLES<2.
- PHASE_GUARD_EN undefined: phase_disable=1 only in HALTED; 0 throughout RUN/STEP.

## Structure
- Package eclair_seq_pkg:
  - state encoding localparams (HALTED=2'd0, RUN=2'd1, STEP=2'd2).
  - PHASE_W=3, DWELL_W=4.
- Sub-module eclair_phase_dwell: dwell counter with hold and terminal-count output.
- The state machine, halt latch and output registers stay in the top module.

## Test plan
All scenarios use defaults and PHASE_GUARD_EN, unless stated otherwise.
- Reset: hold reset_n low → phase=0, phase_disable=1, halted=1, cycle_start=0, cycle_done=0.
- Single step: step pulse → phases 0..7, 2 clocks each, 16 clocks total. phase_disable=1 on the 1st clock of each phase. cycle_done=1 on clock 17 with halted=1 and phase=0. A second step pulse during the cycle has no effect.
- Run: run rising edge, held high for 48 clocks then low → three microcycles. cycle_start at clocks 0, 16 and 32. cycle_done at clocks 16, 32 and 48. halted=1 from clock 48.
- Wait: wait_req high for 5 clocks starting at the last dwell clock of phase 3 → phase 3 lasts 7 clocks with phase_disable=0 while held. Phase 4 follows, and the microcycle is 21 clocks.
- Halt: halt_req pulse in phase 2 with run high → completes phase 7 and enters HALTED. With run still high, it stays halted until run goes low then high again.
- Reset mid-run: reset_n low in phase 5 → outputs take reset values asynchronously. Release reset with run held high → stays HALTED.
